// File: rtl/stream_maxpool.sv
// stream_maxpool: streaming 1-D max-pooling stage.
//
// Reduces each non-overlapping window of K consecutive signed samples of the
// input stream y to its maximum and emits the result on stream z through a
// 2-entry FIFO. Frames are LENY samples long; a short final window is flushed
// at the frame end instead of being merged with the next frame.
//
// Optional feature: define STREAM_LAST_EN to add m_last_z, which marks the
// pooled sample that closes a frame.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous active-low reset
//   s_data_in_y   signed input sample
//   s_valid_y     input sample valid
//   s_ready_y     stage can accept a sample (0 while reset is low)
//   m_data_out_z  signed pooled sample (FIFO head)
//   m_valid_z     m_data_out_z valid
//   m_ready_z     downstream accepts
//   m_last_z      (STREAM_LAST_EN only) pooled sample closes a frame

module stream_maxpool #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LENY  = 5,
  parameter int unsigned K     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [WIDTH-1:0] m_data_out_z,
  output logic             m_valid_z,
  input  logic             m_ready_z
`ifdef STREAM_LAST_EN
  ,
  output logic             m_last_z
`endif
);

  localparam int unsigned WinW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PosW = (LENY > 1) ? $clog2(LENY) : 1;

  localparam logic [WinW-1:0] WinLast = WinW'(K - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(LENY - 1);

  // Window / frame tracking.
  logic [WinW-1:0]         win_q, win_d;
  logic [PosW-1:0]         pos_q, pos_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;

  // Output FIFO.
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       count_q, count_d;
`ifdef STREAM_LAST_EN
  logic             last_mem_q [2];
`endif

  logic                    accept;
  logic                    pop;
  logic                    push;
  logic                    win_end;
  logic                    pos_end;
  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] win_max;

  assign sample  = s_data_in_y;
  assign win_end = (win_q == WinLast);
  assign pos_end = (pos_q == PosLast);

  // Ready depends only on the registered count, never on m_ready_z.
  assign s_ready_y = reset & (count_q != 2'd2);
  assign accept    = s_valid_y & s_ready_y;
  assign m_valid_z = (count_q != 2'd0);
  assign pop       = m_valid_z & m_ready_z;
  assign push      = accept & (win_end | pos_end);

  // First sample of a window starts the max; ties keep the held value.
  always_comb begin
    win_max = sample;
    if (win_q != '0) begin
      win_max = (sample > acc_q) ? sample : acc_q;
    end
  end

  always_comb begin
    acc_d = acc_q;
    win_d = win_q;
    pos_d = pos_q;
    if (accept) begin
      acc_d = win_max;
      win_d = (win_end | pos_end) ? '0 : win_q + WinW'(1);
      pos_d = pos_end ? '0 : pos_q + PosW'(1);
    end
  end

  always_comb begin
    wr_d    = push ? ~wr_q : wr_q;
    rd_d    = pop ? ~rd_q : rd_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      win_q   <= '0;
      pos_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      acc_q   <= acc_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared so m_data_out_z reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= win_max;
    end
  end

  assign m_data_out_z = mem_q[rd_q];

`ifdef STREAM_LAST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_mem_q[0] <= 1'b0;
      last_mem_q[1] <= 1'b0;
    end else if (push) begin
      last_mem_q[wr_q] <= pos_end;
    end
  end

  assign m_last_z = m_valid_z & last_mem_q[rd_q];
`endif

endmodule
